serial_add_sequencer: RTL

Bit-serial add/subtract controller that time-shares a single full-adder cell over WIDTH clock cycles to form a WIDTH-bit sum. It accepts an operand pair through a valid/ready handshake and holds the result until it is consumed. The block is the low-area alternative to a ripple adder for the ALU path. It instantiates the team's FullAdder cell as its only arithmetic element, with no other adder logic.

---
 rtl/serial_add_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial add/subtract built around one FullAdder.
// An operand pair is taken over a valid/ready handshake. The pair is summed
// LSB-first over WIDTH cycles, and the result is held until it is consumed.
//
// Handshake rules: a transfer happens on a rising edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// While out_valid=1 and out_ready=0, sum/carry/overflow hold steady. Inputs
// are not looked at outside the states that use them.
module serial_add_sequencer #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_msb_q, c_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_co;

  // The only arithmetic element. It works on the current LSBs and the running carry.
  FullAdder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .ci  (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_d       = res_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    c_msb_d     = c_msb_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: B is inverted here and the +1 goes in as carry-in.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // carry_q is the carry into the MSB on this cycle
          c_msb_d     = carry_q;
          sum_d       = {fa_s, res_q[WIDTH-1:1]};
          carry_out_d = fa_co;
          ovf_d       = carry_q ^ fa_co;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath flops; asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      c_msb_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      c_msb_q     <= c_msb_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
    end
  end

  // Outputs decode directly from flops, so they are never X after reset
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_RUN);
    out_valid = (state_q == S_DONE);
    sum       = sum_q;
    carry     = carry_out_q;
    overflow  = ovf_q;
  end

endmodule

// FullAdder: one-bit full adder cell.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  // Sum and carry of three input bits
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end
endmodule
